// File: rtl/clock_pkg.sv
// clock_pkg: shared state codes, field limits and BCD helpers
// for the digital clock front end.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HOUR = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_SEC  = 2'b11;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic bcd_t bcd_of(input int v);
    bcd_t r;
    r.tens = 3'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

  localparam bcd_t SEC_LIM  = bcd_of(SEC_MAX);
  localparam bcd_t MIN_LIM  = bcd_of(MIN_MAX);
  localparam bcd_t HOUR_LIM = bcd_of(HOUR_MAX);

  // Ones above 9 are clamped to 9; at or past the limit wraps to 00.
  function automatic bcd_t bcd_inc(
    input bcd_t v,
    input bcd_t lim
  );
    bcd_t       r;
    logic [3:0] ones;
    ones = (v.ones > 4'd9) ? 4'd9 : v.ones;
    r    = '0;
    if ((v.tens > lim.tens) ||
        ((v.tens == lim.tens) && (ones >= lim.ones))) begin
      r = '0;
    end else if (ones == 4'd9) begin
      r.tens = v.tens + 3'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = v.tens;
      r.ones = ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability filter and press pulse.
// The filtered level only moves after DEB_CYCLES steady cycles.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lvl_q;
  logic          lvl_d;
  logic          press_q;
  logic          press_d;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count steady cycles that disagree with the filtered level.
  always_comb begin
    cnt_d   = '0;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d   = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state and one-cycle press pulse.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

  assign level_o = lvl_q;
  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button front end, RUN/SET mode FSM, 1 Hz prescaler
// and preset generation. AUTO_REPEAT_EN adds hold-to-repeat on inc.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEB_MS = 20
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] sec_q0,
  input  logic [2:0] sec_q1,
  input  logic [3:0] min_q0,
  input  logic [2:0] min_q1,
  input  logic [3:0] hour_q0,
  input  logic [1:0] hour_q1,
  output logic       tick_1hz,
  output logic       load_sec,
  output logic       load_min,
  output logic       load_hour,
  output logic [3:0] d0,
  output logic [2:0] d1,
  output logic [1:0] sel,
  output logic       blink
);

  localparam longint DEB_RAW = longint'(CLK_HZ) * DEB_MS / 1000;
  localparam int DEB_CYCLES = (DEB_RAW < 1) ? 1 : int'(DEB_RAW);

  localparam int PRE_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  localparam int BL_CYC = (CLK_HZ >= 8) ? CLK_HZ / 4 : 2;
  localparam int BL_W   = $clog2(BL_CYC);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BL_CYC - 1);

  state_e          state_q;
  state_e          state_d;
  logic            mode_p;
  logic            inc_p;
  logic            mode_lvl;
  logic            inc_lvl;
  logic            inc_fire;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [BL_W-1:0] bl_cnt_q;
  logic [BL_W-1:0] bl_cnt_d;
  logic            blink_q;
  logic            blink_d;
  logic [3:0]      d0_q;
  logic [3:0]      d0_d;
  logic [2:0]      d1_q;
  logic [2:0]      d1_d;
  logic            ld_sec_q;
  logic            ld_sec_d;
  logic            ld_min_q;
  logic            ld_min_d;
  logic            ld_hour_q;
  logic            ld_hour_d;
  bcd_t            cur;
  bcd_t            lim;
  bcd_t            nxt;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_mode (
    .clk    (clk),
    .clr_n  (clr_n),
    .btn_i  (btn_mode),
    .level_o(mode_lvl),
    .press_o(mode_p)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_inc (
    .clk    (clk),
    .clr_n  (clr_n),
    .btn_i  (btn_inc),
    .level_o(inc_lvl),
    .press_o(inc_p)
  );

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_CYC = CLK_HZ / 2;
  localparam int REP_CYC  = (CLK_HZ >= 16) ? CLK_HZ / 8 : 2;
  localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
  localparam int REP_W    = $clog2(REP_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYC - 1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [REP_W-1:0]  rep_q;
  logic [REP_W-1:0]  rep_d;
  logic              armed_q;
  logic              armed_d;
  logic              rep_fire;
  logic              unused_lvl;

  // Hold timer from the press, then a fixed-rate repeat until release.
  always_comb begin
    hold_d   = hold_q;
    rep_d    = rep_q;
    armed_d  = armed_q;
    rep_fire = 1'b0;
    if (!inc_lvl || (state_q == RUN) || mode_p) begin
      hold_d  = '0;
      rep_d   = '0;
      armed_d = 1'b0;
    end else if (!armed_q) begin
      if (hold_q == HOLD_LAST) begin
        armed_d  = 1'b1;
        rep_fire = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end else if (rep_q == REP_LAST) begin
      rep_d    = '0;
      rep_fire = 1'b1;
    end else begin
      rep_d = rep_q + 1'b1;
    end
  end

  // Auto-repeat timer registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hold_q  <= '0;
      rep_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      armed_q <= armed_d;
    end
  end

  assign inc_fire   = inc_p | rep_fire;
  assign unused_lvl = mode_lvl;
`else
  logic unused_lvl;

  assign inc_fire   = inc_p;
  assign unused_lvl = mode_lvl ^ inc_lvl;
`endif

  // Mode press walks the ring RUN -> HOUR -> MIN -> SEC -> RUN.
  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      unique case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Next value of the edited field; a same-cycle mode press wins.
  always_comb begin
    cur       = '0;
    lim       = '0;
    ld_sec_d  = 1'b0;
    ld_min_d  = 1'b0;
    ld_hour_d = 1'b0;
    d0_d      = d0_q;
    d1_d      = d1_q;
    unique case (state_q)
      SET_HOUR: begin
        cur.tens = {1'b0, hour_q1};
        cur.ones = hour_q0;
        lim      = HOUR_LIM;
      end
      SET_MIN: begin
        cur.tens = min_q1;
        cur.ones = min_q0;
        lim      = MIN_LIM;
      end
      SET_SEC: begin
        cur.tens = sec_q1;
        cur.ones = sec_q0;
        lim      = SEC_LIM;
      end
      default: ;
    endcase
    nxt = bcd_inc(cur, lim);
    if (inc_fire && !mode_p && (state_q != RUN)) begin
      d0_d      = nxt.ones;
      d1_d      = nxt.tens;
      ld_hour_d = (state_q == SET_HOUR);
      ld_min_d  = (state_q == SET_MIN);
      ld_sec_d  = (state_q == SET_SEC);
    end
  end

  // Prescaler runs only while staying in RUN; blink only in SET.
  always_comb begin
    pre_d    = '0;
    bl_cnt_d = '0;
    blink_d  = 1'b0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
    if ((state_q != RUN) && (state_d == state_q)) begin
      if (bl_cnt_q == BL_LAST) begin
        blink_d = ~blink_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
        blink_d  = blink_q;
      end
    end
  end

  // State, preset and strobe registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= RUN;
      d0_q      <= '0;
      d1_q      <= '0;
      ld_sec_q  <= 1'b0;
      ld_min_q  <= 1'b0;
      ld_hour_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      ld_sec_q  <= ld_sec_d;
      ld_min_q  <= ld_min_d;
      ld_hour_q <= ld_hour_d;
    end
  end

  // Prescaler and blink phase registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre_q    <= '0;
      bl_cnt_q <= '0;
      blink_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      bl_cnt_q <= bl_cnt_d;
      blink_q  <= blink_d;
    end
  end

  assign tick_1hz  = (state_q == RUN) && (pre_q == PRE_LAST);
  assign load_sec  = ld_sec_q;
  assign load_min  = ld_min_q;
  assign load_hour = ld_hour_q;
  assign d0        = d0_q;
  assign d1        = d1_q;
  assign sel       = state_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl
// at CLK_HZ=1000, DEB_MS=2 (two-cycle debounce).
`timescale 1ns/1ps
module tb_time_set_ctrl;

  localparam int CLK_HZ = 1000;
  localparam int DEB_MS = 2;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] sec_q0 = '0;
  logic [2:0] sec_q1 = '0;
  logic [3:0] min_q0 = '0;
  logic [2:0] min_q1 = '0;
  logic [3:0] hour_q0 = '0;
  logic [1:0] hour_q1 = '0;
  logic       tick_1hz;
  logic       load_sec;
  logic       load_min;
  logic       load_hour;
  logic [3:0] d0;
  logic [2:0] d1;
  logic [1:0] sel;
  logic       blink;

  int n_checks = 0;
  int n_fail = 0;
  int load_seen = 0;
  int tick_seen = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] d1;
    logic [3:0] d0;
  } exp_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] q1;
    logic [3:0] q0;
    logic [2:0] d1;
    logic [3:0] d0;
  } vec_t;

  exp_t sb[$];

  vec_t vecs[11] = '{
    '{2'b01, 3'd2, 4'd3,  3'd0, 4'd0},
    '{2'b01, 3'd1, 4'd9,  3'd2, 4'd0},
    '{2'b01, 3'd0, 4'd9,  3'd1, 4'd0},
    '{2'b01, 3'd1, 4'd5,  3'd1, 4'd6},
    '{2'b10, 3'd5, 4'd9,  3'd0, 4'd0},
    '{2'b10, 3'd0, 4'd9,  3'd1, 4'd0},
    '{2'b10, 3'd3, 4'd4,  3'd3, 4'd5},
    '{2'b10, 3'd2, 4'd12, 3'd3, 4'd0},
    '{2'b11, 3'd5, 4'd9,  3'd0, 4'd0},
    '{2'b11, 3'd4, 4'd2,  3'd4, 4'd3},
    '{2'b11, 3'd1, 4'd15, 3'd2, 4'd0}
  };

  time_set_ctrl #(
    .CLK_HZ(CLK_HZ),
    .DEB_MS(DEB_MS)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_q0   (sec_q0),
    .sec_q1   (sec_q1),
    .min_q0   (min_q0),
    .min_q1   (min_q1),
    .hour_q0  (hour_q0),
    .hour_q1  (hour_q1),
    .tick_1hz (tick_1hz),
    .load_sec (load_sec),
    .load_min (load_min),
    .load_hour(load_hour),
    .d0       (d0),
    .d1       (d1),
    .sel      (sel),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_sec || load_min || load_hour) load_seen++;
    if (tick_1hz) tick_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_mode(output int lat);
    logic [1:0] s0;
    s0 = sel;
    lat = -1;
    btn_mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (lat < 0 && sel !== s0) lat = i;
    end
    btn_mode = 1'b0;
    step(10);
  endtask

  task automatic test_reset();
    int n;
    clr_n = 1'b0;
    step(3);
    n_checks++;
    if ({sel, blink, tick_1hz} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: sel/blink/tick=%b required 0000",
               {sel, blink, tick_1hz});
    end
    n_checks++;
    if ({load_hour, load_min, load_sec, d1, d0} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_data: loads/d1/d0=%b required 0",
               {load_hour, load_min, load_sec, d1, d0});
    end
    clr_n = 1'b1;
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1);
      n++;
      if (tick_1hz) break;
    end
    n_checks++;
    if (n < 999 || n > 1001) begin
      n_fail++;
      $display("FAIL first_tick: after %0d cycles required 999..1001", n);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 0; i < 1100; i++) begin
        step(1);
        n++;
        if (tick_1hz) break;
      end
      n_checks++;
      if (n != 1000) begin
        n_fail++;
        $display("FAIL tick_period: %0d cycles required 1000", n);
      end
    end
    n_checks++;
    if ({sel, blink} !== 3'b000) begin
      n_fail++;
      $display("FAIL run_outputs: sel/blink=%b required 000",
               {sel, blink});
    end
  endtask

  task automatic test_mode_cycle();
    int lat;
    int n;
    int t0;
    logic b;
    logic [1:0] exp_sel[2];
    press_mode(lat);
    n_checks++;
    if (sel !== 2'b01) begin
      n_fail++;
      $display("FAIL enter_hour: sel=%b required 01", sel);
    end
    n_checks++;
    if (lat < 4 || lat > 6) begin
      n_fail++;
      $display("FAIL press_latency: %0d cycles required 4..6", lat);
    end
    t0 = tick_seen;
    b = blink;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (blink !== b) break;
    end
    for (int k = 0; k < 2; k++) begin
      b = blink;
      n = 0;
      for (int i = 0; i < 300; i++) begin
        step(1);
        n++;
        if (blink !== b) break;
      end
      n_checks++;
      if (n != 250) begin
        n_fail++;
        $display("FAIL blink_half: %0d cycles required 250", n);
      end
    end
    exp_sel[0] = 2'b10;
    exp_sel[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      press_mode(lat);
      n_checks++;
      if (sel !== exp_sel[k]) begin
        n_fail++;
        $display("FAIL mode_step: sel=%b required %b", sel, exp_sel[k]);
      end
    end
    n_checks++;
    if (tick_seen != t0) begin
      n_fail++;
      $display("FAIL set_no_tick: %0d ticks required 0", tick_seen - t0);
    end
    btn_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sel === 2'b00) break;
    end
    n_checks++;
    if ({sel, blink} !== 3'b000) begin
      n_fail++;
      $display("FAIL back_to_run: sel/blink=%b required 000",
               {sel, blink});
    end
    // First RUN cycle follows the press cycle, so 999 more edges.
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1);
      n++;
      if (n == 15) btn_mode = 1'b0;
      if (tick_1hz) break;
    end
    btn_mode = 1'b0;
    n_checks++;
    if (n != 999) begin
      n_fail++;
      $display("FAIL reentry_tick: %0d cycles required 999", n);
    end
  endtask

  task automatic test_increment();
    int lat;
    int j;
    logic seen;
    exp_t e;
    exp_t last;
    logic [2:0] exp_ld;
    last = '0;
    foreach (vecs[i]) begin
      for (int k = 0; k < 4 && sel !== vecs[i].sel; k++) press_mode(lat);
      n_checks++;
      if (sel !== vecs[i].sel) begin
        n_fail++;
        $display("FAIL inc_sel[%0d]: sel=%b required %b",
                 i, sel, vecs[i].sel);
      end
      {hour_q1, hour_q0} = {2'd1, 4'd1};
      {min_q1, min_q0}   = {3'd1, 4'd1};
      {sec_q1, sec_q0}   = {3'd1, 4'd1};
      case (vecs[i].sel)
        2'b01:   {hour_q1, hour_q0} = {vecs[i].q1[1:0], vecs[i].q0};
        2'b10:   {min_q1, min_q0}   = {vecs[i].q1, vecs[i].q0};
        default: {sec_q1, sec_q0}   = {vecs[i].q1, vecs[i].q0};
      endcase
      sb.push_back('{vecs[i].sel, vecs[i].d1, vecs[i].d0});
      btn_inc = 1'b1;
      seen = 1'b0;
      j = 0;
      for (int c = 1; c <= 20; c++) begin
        step(1);
        j = c;
        if (load_sec || load_min || load_hour) begin
          seen = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!seen || sb.size() == 0) begin
        n_fail++;
        $display("FAIL inc_load[%0d]: no load strobe in 20 cycles", i);
        if (sb.size() != 0) void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        last = e;
        exp_ld = (e.sel == 2'b01) ? 3'b100 :
                 (e.sel == 2'b10) ? 3'b010 : 3'b001;
        if ({load_hour, load_min, load_sec} !== exp_ld) begin
          n_fail++;
          $display("FAIL inc_strobe[%0d]: h/m/s=%b required %b",
                   i, {load_hour, load_min, load_sec}, exp_ld);
        end
        n_checks++;
        if ({d1, d0} !== {e.d1, e.d0}) begin
          n_fail++;
          $display("FAIL inc_value[%0d]: d1/d0=%0d/%0d required %0d/%0d",
                   i, d1, d0, e.d1, e.d0);
        end
        n_checks++;
        if (j < 4 || j > 6) begin
          n_fail++;
          $display("FAIL inc_latency[%0d]: %0d cycles required 4..6", i, j);
        end
        step(1);
        n_checks++;
        if ({load_hour, load_min, load_sec} !== 3'b000) begin
          n_fail++;
          $display("FAIL inc_width[%0d]: h/m/s=%b required 000",
                   i, {load_hour, load_min, load_sec});
        end
      end
      btn_inc = 1'b0;
      step(12);
    end
    {sec_q1, sec_q0} = {3'd0, 4'd0};
    {min_q1, min_q0} = {3'd5, 4'd9};
    step(30);
    n_checks++;
    if ({d1, d0} !== {last.d1, last.d0}) begin
      n_fail++;
      $display("FAIL d_hold: d1/d0=%0d/%0d required %0d/%0d",
               d1, d0, last.d1, last.d0);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: %0d entries left required 0", sb.size());
    end
  endtask

  task automatic test_run_ignore();
    int lat;
    int l0;
    press_mode(lat);
    n_checks++;
    if (sel !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_run_sel: sel=%b required 00", sel);
    end
    l0 = load_seen;
    btn_inc = 1'b1;
    step(15);
    btn_inc = 1'b0;
    step(10);
    n_checks++;
    if (load_seen != l0) begin
      n_fail++;
      $display("FAIL run_inc_ignored: %0d loads required 0",
               load_seen - l0);
    end
  endtask

  task automatic test_glitch();
    int lat;
    int l0;
    press_mode(lat);
    l0 = load_seen;
    btn_inc = 1'b1;
    step(1);
    btn_inc = 1'b0;
    step(20);
    n_checks++;
    if (load_seen != l0 || sel !== 2'b01) begin
      n_fail++;
      $display("FAIL glitch: loads=%0d sel=%b required 0 and 01",
               load_seen - l0, sel);
    end
  endtask

  task automatic test_coincide();
    int l0;
    l0 = load_seen;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step(15);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(10);
    n_checks++;
    if (sel !== 2'b10) begin
      n_fail++;
      $display("FAIL coincide_sel: sel=%b required 10", sel);
    end
    n_checks++;
    if (load_seen != l0) begin
      n_fail++;
      $display("FAIL coincide_load: %0d loads required 0", load_seen - l0);
    end
  endtask

  task automatic test_hold_inc();
    int l0;
    int n;
    {min_q1, min_q0} = {3'd0, 4'd0};
    l0 = load_seen;
    btn_inc = 1'b1;
    step(1000);
    btn_inc = 1'b0;
    step(20);
    n = load_seen - l0;
`ifdef AUTO_REPEAT_EN
    n_checks++;
    if (n < 4 || n > 6) begin
      n_fail++;
      $display("FAIL hold_repeat: %0d loads required 4..6", n);
    end
`else
    n_checks++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL hold_single: %0d loads required 1", n);
    end
`endif
    n_checks++;
    if ({d1, d0} !== {3'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL hold_value: d1/d0=%0d/%0d required 0/1", d1, d0);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    int l0;
    press_mode(lat);
    n_checks++;
    if (sel !== 2'b11) begin
      n_fail++;
      $display("FAIL enter_sec: sel=%b required 11", sel);
    end
    {sec_q1, sec_q0} = {3'd4, 4'd2};
    btn_inc = 1'b1;
    step(15);
    btn_inc = 1'b0;
    step(10);
    n_checks++;
    if ({d1, d0} !== {3'd4, 4'd3}) begin
      n_fail++;
      $display("FAIL pre_reset_load: d1/d0=%0d/%0d required 4/3", d1, d0);
    end
    l0 = load_seen;
    clr_n = 1'b0;
    #2;
    n_checks++;
    if ({sel, blink, tick_1hz, load_hour, load_min, load_sec, d1, d0}
        !== 14'b0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%b required 0",
               {sel, blink, tick_1hz, load_hour, load_min, load_sec, d1, d0});
    end
    step(3);
    clr_n = 1'b1;
    step(20);
    n_checks++;
    if (load_seen != l0 || sel !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset: loads=%0d sel=%b required 0 and 00",
               load_seen - l0, sel);
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_increment();
    test_run_ignore();
    test_glitch();
    test_coincide();
    test_hold_inc();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-end controller for the digital clock. It debounces the two user buttons and runs the RUN/SET mode state machine. It generates the 1 Hz enable pulse that drives the seconds counter, and produces the load strobes and preset data for the seconds, minutes and hours counters. It sits directly upstream of the mod-60/mod-24 BCD counters and reads their current values back to compute the next preset value.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; sets tick and blink periods
- DEB_MS, 20, debounce window in ms; DEB_CYCLES = CLK_HZ*DEB_MS/1000
- clk  in  1  system clock, rising edge
- clr_n  in  1  reset, asynchronous, active-low
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk
- sec_q0 / sec_q1  in  4 / 3  current seconds BCD (ones/tens)
- min_q0 / min_q1  in  4 / 3  current minutes BCD
- hour_q0 / hour_q1  in  4 / 2  current hours BCD (00–23)
- tick_1hz  out  1  one-cycle enable pulse to the seconds counter
- load_sec, load_min, load_hour  out  1 each  one-cycle load strobes
- d0  out  4  preset ones digit, shared by all three counters
- d1  out  3  preset tens digit, shared; hours use d1[1:0]
- sel  out  2  edited field: 00 none, 01 hour, 10 min, 11 sec
- blink  out  1  2 Hz square wave in SET states, 0 in RUN

## Operation
- Buttons: two-flop synchronizer, then debounce. The debounced level changes only after the synchronized input has been stable for DEB_CYCLES consecutive cycles. A rising edge of the debounced level produces a one-cycle press pulse.
- FSM states and sel encoding: RUN(00), SET_HOUR(01), SET_MIN(10), SET_SEC(11). sel equals the state code.
- Transitions: a mode press advances the state RUN→SET_HOUR→SET_MIN→SET_SEC→RUN. There are no other transitions.
- Prescaler: counts 0..CLK_HZ-1 in RUN only. tick_1hz=1 in the cycle where the count equals CLK_HZ-1. In SET states the prescaler is held at 0 and tick_1hz=0.
- Increment: an inc press in a SET state computes the next value of the selected field.
  - ones+1; if ones was 9, ones→0 and tens+1.
  - 59→00 for minutes and seconds; 23→00 for hours; 09→10 and 19→20.
- The next value is registered onto d0/d1, and the matching load_* strobe is asserted for exactly one cycle.
- An inc press in RUN is ignored.
- Mode and inc presses in the same cycle: mode wins and the inc press is dropped.
- Inc input values that are out of range (ones>9) are treated as 9 in the wrap computation.
- blink: toggles every CLK_HZ/4 cycles in SET states. Its phase counter resets on each state change; blink=0 in RUN.

## Timing
- Reset values: state RUN, tick_1hz=0, load_*=0, d0=0, d1=0, sel=00, blink=0. All counters are cleared.
- Press latency: a raw edge yields a press pulse 2+DEB_CYCLES cycles after the edge, ±1 cycle.
- A press pulse in cycle N gives load_* and d0/d1 valid in cycle N+1. The counter captures the value at the clk edge ending cycle N+1.
- d0/d1 hold their last value until the next load.
- First tick after reset or after entering RUN: CLK_HZ cycles later. Period thereafter: exactly CLK_HZ cycles.
- Reset asserted mid-operation: immediate return to the reset values. No load is issued.

## Configuration
- AUTO_REPEAT_EN defined: in a SET state, holding inc debounced-high for CLK_HZ/2 cycles starts auto-repeat. An increment then fires every CLK_HZ/8 cycles until release.
- Without the macro: exactly one increment per press.

## Structure
- Package clock_pkg holds:
  - the state codes (RUN, SET_HOUR, SET_MIN, SET_SEC)
  - the field limits (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23)
  - the sel encodings
- Sub-module btn_debounce (parameter DEB_CYCLES) contains the synchronizer, stability counter and rising-edge pulse. It is instantiated twice.

## Test plan
- CLK_HZ=1000, DEB_MS=2: release clr_n → tick_1hz first high 1000 cycles later, then every 1000 cycles; sel=00, blink=0.
- Mode press → SET_HOUR, sel=01, tick_1hz stays 0, blink toggles every 250 cycles; three more presses → RUN, first tick 1000 cycles after re-entry.
- SET_MIN with min=5/9, inc press → load_min high one cycle, d1=0, d0=0; min=0/9 → d1=1, d0=0.
- SET_HOUR with hour=2/3 → d1=0, d0=0; hour=1/9 → d1=2, d0=0; no load_sec/load_min pulses.
- Glitch on btn_inc shorter than DEB_CYCLES → no load; mode and inc presses coinciding → state advances, no load; clr_n low while in SET_SEC → RUN and all outputs 0.
- AUTO_REPEAT_EN: hold inc in SET_SEC for 1000 cycles → first load at press, then loads every 125 cycles after the 500-cycle hold.
